pc_seq_unit: RTL and testbench

//  Parametrised next-generation program-counter sequencer for the MIPS core fetch stage.

---
 rtl/pc_seq_unit.sv | 171 +++++++++++++++++
 tb/tb_pc_seq_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer for the fetch stage.
// Picks the next PC from exception, ERET, stall-hold, jump, return, branch
// or sequential sources. It keeps an exception PC, a sticky misaligned-target
// flag and a circular return-address stack (RAS).
module pc_seq_unit #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0]  EXC_VEC   = ADDR_W'(32'h0000_4180),
    parameter int                 RAS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          exc_req,
    input  logic                          eret,
    input  logic                          jump,
    input  logic [ADDR_W-1:0]             jmp_addr,
    input  logic                          ret,
    input  logic [ADDR_W-1:0]             ret_addr,
    input  logic                          link,
    input  logic                          br_taken,
    input  logic [ADDR_W-1:0]             br_addr,
    output logic [ADDR_W-1:0]             pc,
    output logic [ADDR_W-1:0]             pc_plus4,
    output logic [ADDR_W-1:0]             epc,
    output logic                          misalign,
    output logic [$clog2(RAS_DEPTH):0]    ras_cnt
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // A fetch target must be word aligned.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              mis_q, mis_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;      // next free slot; top is ptr_q-1
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] pc4_s;
    logic [ADDR_W-1:0] tgt_s;
    logic [ADDR_W-1:0] top_s;
    logic [PTR_W-1:0]  top_idx_s;
    logic              redir_s;
    logic              push_s;
    logic              pop_s;
    logic              wr_en_s;
    logic [PTR_W-1:0]  wr_idx_s;

    assign pc4_s     = pc_q + ADDR_W'(4);
    assign top_idx_s = ptr_q - PTR_W'(1);
    assign top_s     = ras_q[top_idx_s];

    // Source selection by priority, plus alignment trap on redirect targets.
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = mis_q;
        tgt_s   = pc4_s;
        redir_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (exc_req) begin
            pc_d  = EXC_VEC;
            epc_d = pc_q;
        end else if (eret) begin
            pc_d  = epc_q;
            mis_d = 1'b0;
        end else if (stall) begin
            pc_d  = pc_q;
        end else begin
            if (jump) begin
                tgt_s   = jmp_addr;
                redir_s = 1'b1;
                push_s  = link;
            end else if (ret) begin
                redir_s = 1'b1;
                push_s  = link;
                if (cnt_q != CNT_W'(0)) begin
                    tgt_s = top_s;
                    pop_s = 1'b1;
                end else begin
                    tgt_s = ret_addr;
                end
            end else if (br_taken) begin
                tgt_s   = br_addr;
                redir_s = 1'b1;
            end else begin
                tgt_s   = pc4_s;
            end

            if (redir_s && is_misaligned(tgt_s)) begin
                // Trap the bad target; the pop still stands, the push does not.
                pc_d   = EXC_VEC;
                epc_d  = tgt_s;
                mis_d  = 1'b1;
                push_s = 1'b0;
            end else begin
                pc_d   = tgt_s;
            end
        end
    end

    // RAS pointer/count update; pop+push replaces the top in place.
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        wr_en_s  = 1'b0;
        wr_idx_s = ptr_q;
        if (pop_s && push_s) begin
            wr_en_s  = 1'b1;
            wr_idx_s = top_idx_s;
        end else if (pop_s) begin
            ptr_d = top_idx_s;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (push_s) begin
            wr_en_s  = 1'b1;
            wr_idx_s = ptr_q;
            ptr_d    = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;   // full: the oldest entry was just overwritten
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            mis_q <= 1'b0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            mis_q <= mis_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Return-address stack storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            ras_q[wr_idx_s] <= pc4_s;
        end else begin
            ras_q[wr_idx_s] <= ras_q[wr_idx_s];
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc4_s;
    assign epc      = epc_q;
    assign misalign = mis_q;
    assign ras_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_pc_seq_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h0000_3000;
    localparam logic [31:0] XVEC  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, exc_req = 1'b0, eret = 1'b0, jump = 1'b0;
    logic        ret = 1'b0, link = 1'b0, br_taken = 1'b0;
    logic [31:0] jmp_addr = 32'h0, ret_addr = 32'h0, br_addr = 32'h0;
    logic [31:0] pc, pc_plus4, epc;
    logic        misalign;
    logic [2:0]  ras_cnt;

    pc_seq_unit #(.ADDR_W(32), .RESET_VEC(RVEC), .EXC_VEC(XVEC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req), .eret(eret),
        .jump(jump), .jmp_addr(jmp_addr), .ret(ret), .ret_addr(ret_addr),
        .link(link), .br_taken(br_taken), .br_addr(br_addr),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .misalign(misalign), .ras_cnt(ras_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        mis;
        int          cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc;
    logic        m_mis;
    logic [31:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = RVEC;
        m_epc = 32'h0;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, queue the expectation.
    task automatic step(input logic e, input logic er, input logic st, input logic j,
                        input logic [31:0] ja, input logic r, input logic [31:0] ra,
                        input logic l, input logic b, input logic [31:0] ba);
        logic [31:0] t;
        logic        redir, lnk;
        exp_t        x;
        exc_req = e; eret = er; stall = st; jump = j; jmp_addr = ja;
        ret = r; ret_addr = ra; link = l; br_taken = b; br_addr = ba;
        redir = 1'b0; lnk = 1'b0; t = 32'h0;
        if (e) begin
            m_epc = m_pc;
            m_pc  = XVEC;
        end else if (er) begin
            m_pc  = m_epc;
            m_mis = 1'b0;
        end else if (!st) begin
            if (j) begin
                t = ja; redir = 1'b1; lnk = l;
            end else if (r) begin
                redir = 1'b1; lnk = l;
                if (m_ras.size() > 0) t = m_ras.pop_back();
                else                  t = ra;
            end else if (b) begin
                t = ba; redir = 1'b1;
            end
            if (!redir) begin
                m_pc = m_pc + 32'd4;
            end else if (t[1:0] != 2'b00) begin
                m_epc = t;
                m_mis = 1'b1;
                m_pc  = XVEC;
            end else begin
                if (lnk) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
                m_pc = t;
            end
        end
        x.pc = m_pc; x.epc = m_epc; x.mis = m_mis; x.cnt = m_ras.size();
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic seq();
        step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic jmp(input logic [31:0] a, input logic l);
        step(0, 0, 0, 1, a, 0, 32'h0, l, 0, 32'h0);
    endtask

    task automatic rtn(input logic [31:0] ra, input logic l);
        step(0, 0, 0, 0, 32'h0, 1, ra, l, 0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = RVEC + (32'($urandom_range(0, 1023)) << 2);
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // Monitor: after each rising edge compare the DUT against the oldest expectation.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("pc",       pc,                 x.pc);
            chk("pc_plus4", pc_plus4,           x.pc + 32'd4);
            chk("epc",      epc,                x.epc);
            chk("misalign", {31'h0, misalign},  {31'h0, x.mis});
            chk("ras_cnt",  {29'h0, ras_cnt},   32'(x.cnt));
        end
    end

    initial begin
        logic [31:0] old_pc;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pc",  pc,                RVEC);
        chk("rst_epc", epc,               32'h0);
        chk("rst_mis", {31'h0, misalign}, 32'h0);
        chk("rst_cnt", {29'h0, ras_cnt},  32'h0);
        rst = 1'b1;

        // Reach pc=0x3010 with one RAS entry, then reset asynchronously.
        seq();                       // 3004
        jmp(32'h0000_300C, 1'b1);    // push 3008
        seq();                       // 3010
        rst = 1'b0;
        #1;
        chk("async_rst_pc",  pc,               RVEC);
        chk("async_rst_cnt", {29'h0, ras_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        seq();                       // 3004
        seq();                       // 3008

        // RAS fill and unwind
        jmp(32'h0000_3000, 1'b0);
        jmp(32'h0000_3010, 1'b1);
        jmp(32'h0000_3020, 1'b1);
        jmp(32'h0000_3100, 1'b1);
        rtn(32'h0000_3600, 1'b0);    // 3024
        rtn(32'h0000_3600, 1'b0);    // 3014
        rtn(32'h0000_3600, 1'b0);    // 3004
        rtn(32'h0000_3500, 1'b0);    // empty -> 3500

        // Overflow: five pushes into four entries
        for (int i = 0; i < 5; i++) jmp(32'h0000_3200 + 32'(i * 16), 1'b1);
        for (int i = 0; i < 5; i++) rtn(32'h0000_3700, 1'b0);
        // ret+link on a non-empty stack replaces the top
        jmp(32'h0000_3300, 1'b1);
        rtn(32'h0000_3800, 1'b1);
        rtn(32'h0000_3800, 1'b0);

        // Priority: jump over branch, exception over everything
        step(0, 0, 0, 1, 32'h0000_3100, 0, 32'h0, 0, 1, 32'h0000_3200);
        old_pc = m_pc;
        step(1, 0, 0, 1, 32'h0000_3100, 0, 32'h0, 0, 1, 32'h0000_3200);
        chk("exc_epc_model", m_epc, old_pc);
        // Stall holds for three cycles, exception still taken under stall
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h0000_3400, 1, 32'h0, 1, 1, 32'h0000_3404);
        step(1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);   // eret under stall

        // Misaligned branch, then eret back to it; misaligned ret still pops
        step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0000_3102);
        step(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        jmp(32'h0000_3000, 1'b1);
        jmp(32'h0000_3007, 1'b1);   // trapped, push suppressed
        rtn(32'h0000_3001, 1'b1);   // pops, then traps

        // Wrap past the top of the address space
        jmp(32'hFFFF_FFFC, 1'b0);
        seq();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 5) == 0,  $urandom_range(0, 4) == 0, rand_addr(),
                 $urandom_range(0, 3) == 0,  rand_addr(),
                 $urandom_range(0, 1) == 0,  $urandom_range(0, 3) == 0, rand_addr());
        end
        seq();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
